// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and the decode handshake.
// With FETCH_PERF_EN defined the bus also carries the fetch performance counters.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        input  if_ready,
        output if_valid, if_instruction, if_pc
`ifdef FETCH_PERF_EN
        , output perf_fetched, perf_bubbles
`endif
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        output if_ready,
        input  if_valid, if_instruction, if_pc
`ifdef FETCH_PERF_EN
        , input perf_fetched, perf_bubbles
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests and buffers responses for decode.
// Optional FETCH_PERF_EN adds handshake and bubble counters on the bus.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus_io
);
    localparam int PtrW = $clog2(FIFO_DEPTH);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW:0]   DepthW = (CntW + 1)'(FIFO_DEPTH);
    localparam logic [CntW-1:0] One    = CntW'(1);

    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] fifoCount_q, fifoCount_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] dropCnt_q, dropCnt_d;
    logic [PtrW-1:0] fifoRd_q, fifoRd_d, fifoWr_q, fifoWr_d;
    logic [PtrW-1:0] pcqRd_q, pcqRd_d, pcqWr_q, pcqWr_d;
    logic            initDone_q;

    logic [31:0] fifoInstr_q [FIFO_DEPTH];
    logic [31:0] fifoPc_q    [FIFO_DEPTH];
    logic [31:0] pcQueue_q   [FIFO_DEPTH];

    logic            reqValid, issue, ifValid, pop, push, respValid, redirect;
    logic [CntW:0]   inFlight;

    // Credits: every request in flight owns a FIFO slot, so responses never need backpressure.
    always_comb begin
        redirect  = bus_io.redirect_valid;
        respValid = bus_io.imem_resp_valid;
        inFlight  = {1'b0, fifoCount_q} + {1'b0, outstanding_q};
        reqValid  = !rst && initDone_q && !redirect && (inFlight < DepthW) && (dropCnt_q == '0);
        issue     = reqValid && bus_io.imem_req_ready;
        ifValid   = !rst && (fifoCount_q != '0);
        pop       = ifValid && bus_io.if_ready && !redirect;
        push      = respValid && (dropCnt_q == '0) && !redirect;

        outstanding_d = outstanding_q;
        if (issue && !respValid) begin
            outstanding_d = outstanding_q + One;
        end else if (!issue && respValid) begin
            outstanding_d = outstanding_q - One;
        end

        dropCnt_d = dropCnt_q;
        if (redirect) begin
            dropCnt_d = outstanding_d;
        end else if (respValid && (dropCnt_q != '0)) begin
            dropCnt_d = dropCnt_q - One;
        end

        pc_d = pc_q;
        if (redirect) begin
            pc_d = {bus_io.redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end

        fifoCount_d = fifoCount_q;
        fifoRd_d    = fifoRd_q + PtrW'(pop);
        fifoWr_d    = fifoWr_q + PtrW'(push);
        if (redirect) begin
            fifoCount_d = '0;
            fifoRd_d    = fifoWr_q;
        end else if (push && !pop) begin
            fifoCount_d = fifoCount_q + One;
        end else if (!push && pop) begin
            fifoCount_d = fifoCount_q - One;
        end

        // The PC queue is never flushed: dropped responses still retire their recorded PC.
        pcqWr_d = pcqWr_q + PtrW'(issue);
        pcqRd_d = pcqRd_q + PtrW'(respValid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            fifoCount_q   <= '0;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
            fifoRd_q      <= '0;
            fifoWr_q      <= '0;
            pcqRd_q       <= '0;
            pcqWr_q       <= '0;
            initDone_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fifoCount_q   <= fifoCount_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
            fifoRd_q      <= fifoRd_d;
            fifoWr_q      <= fifoWr_d;
            pcqRd_q       <= pcqRd_d;
            pcqWr_q       <= pcqWr_d;
            initDone_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pcQueue_q[pcqWr_q] <= pc_q;
        end
        if (push) begin
            fifoInstr_q[fifoWr_q] <= bus_io.imem_resp_data;
            fifoPc_q[fifoWr_q]    <= pcQueue_q[pcqRd_q];
        end
    end

    assign bus_io.imem_req_valid = reqValid;
    assign bus_io.imem_req_addr  = pc_q;
    assign bus_io.if_valid       = ifValid;
    assign bus_io.if_instruction = ifValid ? fifoInstr_q[fifoRd_q] : 32'h0;
    assign bus_io.if_pc          = ifValid ? fifoPc_q[fifoRd_q] : 32'h0;

`ifdef FETCH_PERF_EN
    logic [31:0] perfFetched_q, perfBubbles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perfFetched_q <= '0;
            perfBubbles_q <= '0;
        end else begin
            if (pop) begin
                perfFetched_q <= perfFetched_q + 32'd1;
            end
            if (bus_io.if_ready && !ifValid) begin
                perfBubbles_q <= perfBubbles_q + 32'd1;
            end
        end
    end

    assign bus_io.perf_fetched = perfFetched_q;
    assign bus_io.perf_bubbles = perfBubbles_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table against a 1-cycle memory plus redirect/latency/wrap sequences.
// Perf counter checks are compiled only when FETCH_PERF_EN is defined.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .bus_io(bus.master)
    );
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .bus_io(bus2.master)
    );

    int total = 0;
    int bad   = 0;

    // In-order memory model with programmable latency; response data equals the request address.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;
    memReq_t memQ[$];
    int memLat = 1;
    int cyc    = 0;

    always @(posedge clk) begin
        if (rst) begin
            memQ.delete();
            bus.imem_resp_valid <= 1'b0;
            bus.imem_resp_data  <= 32'h0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                memQ.push_back('{bus.imem_req_addr, cyc + memLat});
            end
            if (memQ.size() > 0 && memQ[0].due <= cyc + 1) begin
                bus.imem_resp_valid <= 1'b1;
                bus.imem_resp_data  <= memQ[0].addr;
                void'(memQ.pop_front());
            end else begin
                bus.imem_resp_valid <= 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    logic [31:0] addrLog2[$];
    always @(posedge clk) begin
        if (rst) begin
            addrLog2.delete();
            bus2.imem_resp_valid <= 1'b0;
            bus2.imem_resp_data  <= 32'h0;
        end else begin
            bus2.imem_resp_valid <= bus2.imem_req_valid && bus2.imem_req_ready;
            bus2.imem_resp_data  <= bus2.imem_req_addr;
            if (bus2.imem_req_valid && bus2.imem_req_ready) begin
                addrLog2.push_back(bus2.imem_req_addr);
            end
        end
    end

    typedef struct packed {
        logic        ifReady;
        logic        expReqValid;
        logic [31:0] expReqAddr;
        logic        expIfValid;
        logic        chkData;
        logic [31:0] expPc;
    } vec_t;
    vec_t vecs[$];

    function automatic void addVec(logic r, logic qv, logic [31:0] a, logic iv, logic c, logic [31:0] p);
        vec_t v;
        v.ifReady     = r;
        v.expReqValid = qv;
        v.expReqAddr  = a;
        v.expIfValid  = iv;
        v.chkData     = c;
        v.expPc       = p;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        bus.if_ready = v.ifReady;
        #1;
        checkOutput($sformatf("row%0d_reqValid", idx), {31'b0, bus.imem_req_valid}, {31'b0, v.expReqValid});
        checkOutput($sformatf("row%0d_reqAddr", idx), bus.imem_req_addr, v.expReqAddr);
        checkOutput($sformatf("row%0d_ifValid", idx), {31'b0, bus.if_valid}, {31'b0, v.expIfValid});
        if (v.chkData) begin
            checkOutput($sformatf("row%0d_ifPc", idx), bus.if_pc, v.expPc);
            checkOutput($sformatf("row%0d_ifInstr", idx), bus.if_instruction, v.expPc);
        end
        @(negedge clk);
    endtask

    // Leaves the bench at a negedge in the first cycle after reset, with reset released.
    task automatic doReset(input string tag);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput({tag, "_rstReqValid"}, {31'b0, bus.imem_req_valid}, 32'h0);
        checkOutput({tag, "_rstIfValid"}, {31'b0, bus.if_valid}, 32'h0);
        checkOutput({tag, "_rstIfPc"}, bus.if_pc, 32'h0);
        checkOutput({tag, "_rstIfInstr"}, bus.if_instruction, 32'h0);
        rst = 1'b0;
    endtask

    task automatic waitIfValid(input string tag, input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.if_valid) found = 1'b1;
        end
        checkOutput({tag, "_waitIfValid"}, {31'b0, found}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;
        logic [31:0] a;

        rst = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b1;
        bus2.imem_req_ready = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'h0;
        bus2.if_ready       = 1'b1;

        // Credit of 2 with 1-cycle memory: request/deliver pattern repeats every 3 cycles.
        addVec(1, 0, 32'd0,  0, 1, 32'd0);
        addVec(1, 1, 32'd0,  0, 0, 32'd0);
        addVec(1, 1, 32'd4,  0, 0, 32'd0);
        addVec(1, 0, 32'd8,  1, 1, 32'd0);
        addVec(1, 1, 32'd8,  1, 1, 32'd4);
        addVec(1, 1, 32'd12, 0, 0, 32'd0);
        addVec(1, 0, 32'd16, 1, 1, 32'd8);
        addVec(1, 1, 32'd16, 1, 1, 32'd12);
        addVec(1, 1, 32'd20, 0, 0, 32'd0);
        for (int i = 0; i < 5; i++) addVec(0, 0, 32'd24, 1, 1, 32'd16);
        addVec(1, 0, 32'd24, 1, 1, 32'd16);
        addVec(1, 1, 32'd24, 1, 1, 32'd20);
        addVec(1, 1, 32'd28, 0, 0, 32'd0);
        addVec(1, 0, 32'd32, 1, 1, 32'd24);

        memLat = 1;
        doReset("table");
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        checkOutput("wrapCount", (addrLog2.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            a = (addrLog2.size() > i) ? addrLog2[i] : 32'hDEAD_BEEF;
            checkOutput($sformatf("wrapAddr%0d", i), a, 32'hFFFF_FFF8 + 32'(4 * i));
        end

        // 3-cycle memory, redirect with two requests outstanding.
        memLat = 3;
        bus.if_ready = 1'b1;
        doReset("redir");
        #1;
        checkOutput("redir_c1ReqValid", {31'b0, bus.imem_req_valid}, 32'h0);
        @(negedge clk); #1;
        checkOutput("redir_c2Addr", bus.imem_req_addr, 32'h0);
        @(negedge clk); #1;
        checkOutput("redir_c3Addr", bus.imem_req_addr, 32'h4);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        checkOutput("redir_pulseReqValid", {31'b0, bus.imem_req_valid}, 32'h0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checkOutput("redir_c5ReqValid", {31'b0, bus.imem_req_valid}, 32'h0);
        checkOutput("redir_c5Addr", bus.imem_req_addr, 32'h100);
        @(negedge clk); #1;
        checkOutput("redir_c6IfValid", {31'b0, bus.if_valid}, 32'h0);
        checkOutput("redir_c6ReqValid", {31'b0, bus.imem_req_valid}, 32'h0);
        @(negedge clk); #1;
        checkOutput("redir_c7ReqValid", {31'b0, bus.imem_req_valid}, 32'h1);
        waitIfValid("redir", 12, found);
        checkOutput("redir_firstPc", bus.if_pc, 32'h100);
        checkOutput("redir_firstInstr", bus.if_instruction, 32'h100);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checkOutput("redir203_addr", bus.imem_req_addr, 32'h200);
        checkOutput("redir203_ifValid", {31'b0, bus.if_valid}, 32'h0);

        // Redirect coinciding with a response while decode is ready.
        memLat = 1;
        bus.if_ready = 1'b1;
        doReset("same");
        repeat (3) @(negedge clk);
        #1;
        checkOutput("same_c4IfValid", {31'b0, bus.if_valid}, 32'h1);
        checkOutput("same_c4RespValid", {31'b0, bus.imem_resp_valid}, 32'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checkOutput("same_c5IfValid", {31'b0, bus.if_valid}, 32'h0);
        checkOutput("same_c5ReqValid", {31'b0, bus.imem_req_valid}, 32'h1);
        checkOutput("same_c5Addr", bus.imem_req_addr, 32'h40);
`ifdef FETCH_PERF_EN
        checkOutput("same_perfFetched", bus.perf_fetched, 32'd0);
        checkOutput("same_perfBubbles", bus.perf_bubbles, 32'd3);
`endif
        waitIfValid("same", 8, found);
        checkOutput("same_firstPc", bus.if_pc, 32'h40);
        checkOutput("same_firstInstr", bus.if_instruction, 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
